// File: rtl/video_stitching_pkg.sv
// video_stitching_pkg: shared lane geometry and the buffered word format for the stitching write path.
package video_stitching_pkg;
  localparam int LANE_W = 32;
  localparam int AXI_W = 128;
  typedef struct packed {
    logic [AXI_W-1:0] data;
    logic             user;
    logic             last;
  } word_t;
  function automatic int pix_per_word(input int axi_w);
    return axi_w / LANE_W;
  endfunction
endpackage

// File: rtl/stream_skid_fifo.sv
// stream_skid_fifo: 2-entry FIFO; a push while full is dropped unless a pop frees the slot that cycle.
module stream_skid_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [2];
  logic         wp, rp, do_push, do_pop;
  logic [1:0]   cnt;
  always_comb begin
    do_pop = pop & !empty;
    do_push = push & (!full | do_pop);
  end
  always_ff @(posedge clk)
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      cnt <= '0;
    end else begin
      if (do_push) mem[wp] <= din;
      wp <= do_push ? !wp : wp;
      rp <= do_pop ? !rp : rp;
      cnt <= cnt + 2'(do_push) - 2'(do_pop);
    end
  assign dout = mem[rp];
  assign full = cnt[1];
  assign empty = cnt == '0;
endmodule

// File: rtl/cmos_stream_packer.sv
// cmos_stream_packer: packs a CMOS pixel stream into wide words with frame-start/end-of-line sideband.
module cmos_stream_packer
  import video_stitching_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int AXI_DATA_WIDTH = AXI_W,
  parameter int IMG_HDISP = 960,
  parameter int IMG_VDISP = 1080
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmos_vsync,
  input  logic                      cmos_href,
  input  logic                      cmos_clken,
  input  logic [DATA_WIDTH-1:0]     cmos_data,
  output logic [AXI_DATA_WIDTH-1:0] m_tdata,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic                      m_tuser,
  output logic                      m_tlast,
  output logic                      frame_done,
  output logic                      overflow,
  output logic                      line_err
);
  localparam int PPW = pix_per_word(AXI_DATA_WIDTH);
  localparam int LW = PPW > 1 ? $clog2(PPW) : 1;
  localparam int PW = $clog2(IMG_HDISP + 1);
  localparam int VW = $clog2(IMG_VDISP + 1);
  localparam logic [LW-1:0] LAST_LANE = LW'(PPW - 1);
  localparam logic [PW-1:0] HD = PW'(IMG_HDISP);
  localparam logic [VW-1:0] VD = VW'(IMG_VDISP);
  localparam logic [VW-1:0] LAST_LINE = VW'(IMG_VDISP - 1);

  logic                      vsync_d, href_d, sof;
  logic [LW-1:0]             lane, eff_lane;
  logic [PW-1:0]             pix_cnt, eff_pix;
  logic [VW-1:0]             line_cnt, eff_line;
  logic [AXI_DATA_WIDTH-1:0] asm_q, asm_next;
  logic                      vs_rise, hr_fall, accept, push_word, push_part, push, pop, full, empty;
  word_t                     word, head;

  // A vsync rise resets the frame before the same-cycle pixel is considered.
  always_comb begin
    vs_rise = cmos_vsync & !vsync_d;
    hr_fall = !cmos_href & href_d & !vs_rise;
    eff_lane = vs_rise ? '0 : lane;
    eff_pix = vs_rise ? '0 : pix_cnt;
    eff_line = vs_rise ? '0 : line_cnt;
    accept = cmos_href & cmos_clken & (eff_pix < HD);
    push_word = accept & (eff_lane == LAST_LANE);
    push_part = hr_fall & (pix_cnt < HD) & (lane != '0);
    push = push_word | push_part;
    asm_next = eff_lane == '0 ? '0 : asm_q;
    for (int k = 0; k < PPW; k++)
      if (eff_lane == LW'(k)) asm_next[k*LANE_W +: LANE_W] = LANE_W'(cmos_data);
    word.data = push_word ? asm_next : asm_q;
    word.user = vs_rise | sof;
    word.last = push_part | (eff_pix + 1'b1 == HD);
    pop = !empty & m_tready;
  end

  always_ff @(posedge clk)
    if (rst) begin
      vsync_d <= 1'b0;
      href_d <= 1'b0;
      sof <= 1'b0;
      lane <= '0;
      pix_cnt <= '0;
      line_cnt <= '0;
      asm_q <= '0;
      frame_done <= 1'b0;
      overflow <= 1'b0;
      line_err <= 1'b0;
    end else begin
      vsync_d <= cmos_vsync;
      href_d <= cmos_href;
      lane <= accept ? (eff_lane == LAST_LANE ? '0 : eff_lane + 1'b1) : (vs_rise | hr_fall) ? '0 : lane;
      pix_cnt <= accept ? eff_pix + 1'b1 : (vs_rise | hr_fall) ? '0 : pix_cnt;
      line_cnt <= vs_rise ? '0 : (hr_fall & (line_cnt != VD)) ? line_cnt + 1'b1 : line_cnt;
      sof <= push ? 1'b0 : vs_rise ? 1'b1 : sof;
      if (accept) asm_q <= asm_next;
      frame_done <= push & word.last & (eff_line == LAST_LINE);
      overflow <= overflow | (push & full & !pop);
      line_err <= line_err | (cmos_href & cmos_clken & (eff_pix == HD)) | (hr_fall & (pix_cnt < HD));
    end

  stream_skid_fifo #(.W($bits(word_t))) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  (word),
    .dout (head),
    .full (full),
    .empty(empty)
  );

  assign m_tvalid = !empty;
  assign m_tdata = head.data;
  assign m_tuser = head.user;
  assign m_tlast = head.last;
endmodule

// File: tb/tb_cmos_stream_packer.sv
// tb_cmos_stream_packer: directed stimulus with a queue-based scoreboard and an independent output monitor.
module tb_cmos_stream_packer;
  logic         clk = 1'b0, rst = 1'b1;
  logic         cmos_vsync = 1'b0, cmos_href = 1'b0, cmos_clken = 1'b0, m_tready = 1'b1;
  logic [23:0]  cmos_data = '0;
  logic [127:0] m_tdata;
  logic         m_tvalid, m_tuser, m_tlast, frame_done, overflow, line_err;

  typedef struct {
    logic [127:0] d;
    logic         u;
    logic         l;
    logic [1:0]   fd;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0, errors = 0, fd_cnt = 0, fd0;

  cmos_stream_packer #(
    .DATA_WIDTH(24), .AXI_DATA_WIDTH(128), .IMG_HDISP(8), .IMG_VDISP(2)
  ) dut (
    .clk(clk), .rst(rst), .cmos_vsync(cmos_vsync), .cmos_href(cmos_href),
    .cmos_clken(cmos_clken), .cmos_data(cmos_data), .m_tdata(m_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tuser(m_tuser), .m_tlast(m_tlast),
    .frame_done(frame_done), .overflow(overflow), .line_err(line_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

  always @(negedge clk)
    if (!rst && m_tvalid === 1'b1 && m_tready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL extra_word got data=%h user=%b last=%b, none expected", m_tdata, m_tuser, m_tlast);
      end else begin
        e = q.pop_front();
        if (m_tdata !== e.d || m_tuser !== e.u || m_tlast !== e.l || (e.fd[1] && frame_done !== e.fd[0])) begin
          errors++;
          $display("FAIL word got data=%h user=%b last=%b fd=%b expected data=%h user=%b last=%b fd=%b",
                   m_tdata, m_tuser, m_tlast, frame_done, e.d, e.u, e.l, e.fd[0]);
        end
      end
    end

  function automatic logic [127:0] w4(input logic [31:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic exp_word(input logic [127:0] d, input logic u, l, input logic [1:0] fd = 2'b00);
    q.push_back('{d, u, l, fd});
  endtask

  task automatic check(input string name, input logic [127:0] got, exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic [23:0] v);
    cmos_href = 1'b1;
    cmos_clken = 1'b1;
    cmos_data = v;
    tick;
  endtask

  task end_line;
    cmos_href = 1'b0;
    cmos_clken = 1'b0;
    tick;
    tick;
  endtask

  task automatic line(input int n, input int base);
    for (int i = 0; i < n; i++) pix(24'(base + i));
    end_line;
  endtask

  task vsync_pulse;
    cmos_vsync = 1'b1;
    tick;
    cmos_vsync = 1'b0;
    tick;
  endtask

  task do_reset;
    rst = 1'b1;
    tick;
    rst = 1'b0;
  endtask

  task drain;
    repeat (8) tick;
    check("queue_drained", 128'(q.size()), 128'd0);
  endtask

  localparam logic [127:0] WA = {32'd4, 32'd3, 32'd2, 32'd1};
  localparam logic [127:0] WB = {32'd8, 32'd7, 32'd6, 32'd5};

  initial begin
    repeat (2) tick;
    check("rst_tvalid", 128'(m_tvalid), 128'd0);
    check("rst_tdata", m_tdata, 128'd0);
    check("rst_tuser", 128'(m_tuser), 128'd0);
    check("rst_tlast", 128'(m_tlast), 128'd0);
    check("rst_frame_done", 128'(frame_done), 128'd0);
    check("rst_overflow", 128'(overflow), 128'd0);
    check("rst_line_err", 128'(line_err), 128'd0);
    rst = 1'b0;

    fd0 = fd_cnt;
    exp_word(WA, 1'b1, 1'b0, 2'b10);
    exp_word(WB, 1'b0, 1'b1, 2'b10);
    exp_word(WA, 1'b0, 1'b0, 2'b10);
    exp_word(WB, 1'b0, 1'b1, 2'b11);
    vsync_pulse;
    line(8, 1);
    line(8, 1);
    drain;
    check("nom_frame_done_count", 128'(fd_cnt - fd0), 128'd1);
    check("nom_line_err", 128'(line_err), 128'd0);
    check("nom_overflow", 128'(overflow), 128'd0);

    do_reset;
    m_tready = 1'b0;
    vsync_pulse;
    line(8, 1);
    check("bp_overflow_line0", 128'(overflow), 128'd0);
    check("bp_tvalid", 128'(m_tvalid), 128'd1);
    check("bp_hold_data0", m_tdata, WA);
    check("bp_hold_user", 128'(m_tuser), 128'd1);
    repeat (3) tick;
    check("bp_hold_data1", m_tdata, WA);
    check("bp_hold_last", 128'(m_tlast), 128'd0);
    for (int i = 1; i <= 4; i++) pix(24'(i));
    check("bp_overflow_set", 128'(overflow), 128'd1);
    for (int i = 5; i <= 8; i++) pix(24'(i));
    end_line;
    exp_word(WA, 1'b1, 1'b0);
    exp_word(WB, 1'b0, 1'b1);
    m_tready = 1'b1;
    drain;
    check("bp_empty_after", 128'(m_tvalid), 128'd0);

    do_reset;
    exp_word(WA, 1'b1, 1'b0);
    exp_word(w4(5, 6, 0, 0), 1'b0, 1'b1);
    vsync_pulse;
    line(6, 1);
    drain;
    check("short_line_err", 128'(line_err), 128'd1);
    check("short_overflow", 128'(overflow), 128'd0);

    do_reset;
    exp_word(WA, 1'b1, 1'b0);
    exp_word(WB, 1'b0, 1'b1);
    vsync_pulse;
    line(10, 1);
    drain;
    check("long_line_err", 128'(line_err), 128'd1);

    do_reset;
    exp_word(WA, 1'b1, 1'b0);
    exp_word(w4(32'h11, 32'h12, 32'h13, 32'h14), 1'b1, 1'b0);
    exp_word(w4(32'h15, 32'h16, 32'h17, 32'h18), 1'b0, 1'b1);
    vsync_pulse;
    for (int i = 1; i <= 7; i++) pix(24'(i));
    cmos_vsync = 1'b1;
    pix(24'h11);
    cmos_vsync = 1'b0;
    for (int i = 'h12; i <= 'h18; i++) pix(24'(i));
    end_line;
    drain;
    check("mid_vsync_line_err", 128'(line_err), 128'd0);

    do_reset;
    m_tready = 1'b0;
    vsync_pulse;
    for (int i = 1; i <= 4; i++) pix(24'(i));
    cmos_href = 1'b0;
    cmos_clken = 1'b0;
    tick;
    check("rstm_tvalid_before", 128'(m_tvalid), 128'd1);
    check("rstm_line_err_before", 128'(line_err), 128'd1);
    do_reset;
    check("rstm_tvalid_after", 128'(m_tvalid), 128'd0);
    check("rstm_tdata_after", m_tdata, 128'd0);
    check("rstm_line_err_after", 128'(line_err), 128'd0);
    check("rstm_overflow_after", 128'(overflow), 128'd0);
    m_tready = 1'b1;
    fd0 = fd_cnt;
    exp_word(WA, 1'b1, 1'b0);
    exp_word(WB, 1'b0, 1'b1);
    exp_word(WA, 1'b0, 1'b0);
    exp_word(WB, 1'b0, 1'b1, 2'b11);
    vsync_pulse;
    line(8, 1);
    line(8, 1);
    drain;
    check("rstm_frame_done_count", 128'(fd_cnt - fd0), 128'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
